// File: rtl/param_register_file.sv
// rtl/param_register_file.sv - parametrised 2R/1W register file with write bypass and sequential bulk clear
module param_register_file #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [WIDTH-1:0]  rd_data1,
    output logic [WIDTH-1:0]  rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              wr_ready,
    input  logic              clear_req,
    output logic              busy,
    output logic              clear_done
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nxt;
    logic              done_nxt;
    logic              wr_store;
    logic [WIDTH-1:0]  mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            clear_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            clear_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                idx_nxt = '0;
                if (clear_req) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                if (idx == LAST_IDX) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                    done_nxt  = 1'b1;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    assign busy     = (state == CLEAR);
    assign wr_ready = (state == IDLE);

    // Writes to a hardwired-zero entry complete the handshake but never reach storage or the bypass.
    assign wr_store = wr_en && wr_ready && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (busy) begin
            mem[idx] <= '0;
        end else if (wr_store) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data1 = mem[rd_addr1];
        if ((ZERO_REG != 0) && (rd_addr1 == '0)) begin
            rd_data1 = '0;
        end else if (busy) begin
            rd_data1 = '0;
        end else if ((BYPASS != 0) && wr_store && (rd_addr1 == wr_addr)) begin
            rd_data1 = wr_data;
        end
    end

    always_comb begin
        rd_data2 = mem[rd_addr2];
        if ((ZERO_REG != 0) && (rd_addr2 == '0)) begin
            rd_data2 = '0;
        end else if (busy) begin
            rd_data2 = '0;
        end else if ((BYPASS != 0) && wr_store && (rd_addr2 == wr_addr)) begin
            rd_data2 = wr_data;
        end
    end

endmodule

// File: tb/tb_param_register_file.sv
// tb/tb_param_register_file.sv - scoreboard bench for param_register_file (default, no-bypass and zero-reg builds)
module tb_param_register_file;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  rd_addr1 = '0;
    logic [3:0]  rd_addr2 = '0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        clear_req = 1'b0;

    logic [15:0] a_rd1, a_rd2, n_rd1, n_rd2, z_rd1, z_rd2;
    logic        a_ready, a_busy, a_done;
    logic        n_ready, n_busy, n_done;
    logic        z_ready, z_busy, z_done;

    always #5 clk = ~clk;

    param_register_file #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(a_rd1), .rd_data2(a_rd2), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(a_ready), .clear_req(clear_req),
        .busy(a_busy), .clear_done(a_done)
    );

    param_register_file #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(n_rd1), .rd_data2(n_rd2), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(n_ready), .clear_req(clear_req),
        .busy(n_busy), .clear_done(n_done)
    );

    param_register_file #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) dut_z (
        .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(z_rd1), .rd_data2(z_rd2), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(z_ready), .clear_req(clear_req),
        .busy(z_busy), .clear_done(z_done)
    );

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } sb_t;

    sb_t         sb_q[$];
    int          vec_count = 0;
    int          miscompares = 0;

    logic [15:0] m_mem [16];
    logic [15:0] z_mem [16];
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_idx = 0;
    int          busy_cycles;
    int          done_pulses;

    task automatic check_vec(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec_count++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [15:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [15:0] obs);
        sb_t e;
        if (sb_q.size() == 0) begin
            check_vec("scoreboard_underflow", obs, 16'hxxxx);
        end else begin
            e = sb_q.pop_front();
            check_vec(e.tag, obs, e.exp);
        end
    endtask

    function automatic logic [15:0] exp_rd(input logic [3:0] a, input bit zr, input bit bp);
        if (zr && a == 4'd0) return 16'h0000;
        if (m_busy) return 16'h0000;
        if (bp && wr_en && !(zr && wr_addr == 4'd0) && a == wr_addr) return wr_data;
        return zr ? z_mem[a] : m_mem[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_mem[i] = '0;
            z_mem[i] = '0;
        end
        m_busy = 1'b0;
        m_done = 1'b0;
        m_idx  = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            if (!m_busy) begin
                m_done = 1'b0;
                if (wr_en) begin
                    m_mem[wr_addr] = wr_data;
                    if (wr_addr != 4'd0) z_mem[wr_addr] = wr_data;
                end
                if (clear_req) begin
                    m_busy = 1'b1;
                    m_idx  = 0;
                end
            end else begin
                m_mem[m_idx] = '0;
                z_mem[m_idx] = '0;
                if (m_idx == 15) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_idx  = 0;
                end else begin
                    m_idx++;
                end
            end
        end
        #1;
    endtask

    task automatic check_all(input string ph);
        #1;
        sb_push({ph, "/rd1"},   exp_rd(rd_addr1, 1'b0, 1'b1));
        sb_push({ph, "/rd2"},   exp_rd(rd_addr2, 1'b0, 1'b1));
        sb_push({ph, "/nb_rd1"}, exp_rd(rd_addr1, 1'b0, 1'b0));
        sb_push({ph, "/nb_rd2"}, exp_rd(rd_addr2, 1'b0, 1'b0));
        sb_push({ph, "/z_rd1"}, exp_rd(rd_addr1, 1'b1, 1'b1));
        sb_push({ph, "/z_rd2"}, exp_rd(rd_addr2, 1'b1, 1'b1));
        sb_push({ph, "/busy"},  {15'd0, m_busy});
        sb_push({ph, "/ready"}, {15'd0, !m_busy});
        sb_push({ph, "/done"},  {15'd0, m_done});
        sb_push({ph, "/z_ready"}, {15'd0, !m_busy});
        sb_pop(a_rd1);
        sb_pop(a_rd2);
        sb_pop(n_rd1);
        sb_pop(n_rd2);
        sb_pop(z_rd1);
        sb_pop(z_rd2);
        sb_pop({15'd0, a_busy});
        sb_pop({15'd0, a_ready});
        sb_pop({15'd0, a_done});
        sb_pop({15'd0, z_ready});
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Basic write then read, plus an untouched neighbour.
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
        tick();
        wr_en = 1'b0; rd_addr1 = 4'd5; rd_addr2 = 4'd6;
        check_all("wr_r5");
        check_vec("r5_const", a_rd1, 16'hBEEF);
        check_vec("r6_const", a_rd2, 16'h0000);

        // Same-cycle bypass on both ports.
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234; rd_addr1 = 4'd3; rd_addr2 = 4'd3;
        check_all("bypass");
        check_vec("bypass_const", a_rd2, 16'h1234);
        check_vec("nobypass_const", n_rd1, 16'h0000);
        tick();
        wr_en = 1'b0;
        check_all("bypass_after");

        // Writes to R0: discarded in the zero-reg build, stored elsewhere.
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF; rd_addr1 = 4'd0; rd_addr2 = 4'd0;
        check_all("r0_write");
        tick();
        wr_en = 1'b0;
        check_all("r0_after");
        check_vec("r0_zero_const", z_rd1, 16'h0000);
        check_vec("r0_plain_const", a_rd1, 16'hFFFF);

        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'h1000 + 16'(i);
            rd_addr1 = 4'(i); rd_addr2 = 4'(i + 1);
            check_all($sformatf("fill%0d", i));
            tick();
        end

        // Clear request with a concurrent write to R7, then hold a write to R9 through the sweep.
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'hAAAA; clear_req = 1'b1; rd_addr1 = 4'd7; rd_addr2 = 4'd2;
        check_all("clr_req");
        tick();
        clear_req = 1'b0; wr_addr = 4'd9; wr_data = 16'h5555; rd_addr1 = 4'd9; rd_addr2 = 4'd15;
        busy_cycles = 0;
        done_pulses = 0;
        for (int c = 0; c < 20; c++) begin
            check_all($sformatf("sweep%0d", c));
            if (a_busy) busy_cycles++;
            if (a_done) done_pulses++;
            tick();
        end
        wr_en = 1'b0;
        check_vec("busy_cycles", 16'(busy_cycles), 16'd16);
        check_vec("done_pulses", 16'(done_pulses), 16'd1);
        for (int i = 0; i < 16; i++) begin
            rd_addr1 = 4'(i); rd_addr2 = 4'(15 - i);
            check_all($sformatf("post%0d", i));
        end
        rd_addr1 = 4'd7; rd_addr2 = 4'd9;
        #1;
        check_vec("r7_wiped", a_rd1, 16'h0000);
        check_vec("r9_held_write", a_rd2, 16'h5555);

        // Abort a sweep at index 8 with an asynchronous reset.
        tick();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'h2000 + 16'(i);
            tick();
        end
        wr_en = 1'b0; clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (8) tick();
        check_vec("mid_sweep_busy", {15'd0, a_busy}, 16'd1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_vec("rst_busy", {15'd0, a_busy}, 16'd0);
        check_vec("rst_done", {15'd0, a_done}, 16'd0);
        for (int i = 0; i < 16; i++) begin
            rd_addr1 = 4'(i); rd_addr2 = 4'(i);
            check_all($sformatf("rst_rd%0d", i));
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        rd_addr1 = 4'd12; rd_addr2 = 4'd4;
        check_all("released");
        check_vec("released_ready", {15'd0, a_ready}, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
